nec_cmd_scheduler: RTL and testbench

- Sits between the NEC IR receiver and the Wishbone register block of the user project.
- Validates decoded NEC frames (complement check, optional address filter) and tracks key-held state from NEC repeat codes.
- Schedules PRESS / REPEAT / RELEASE command events into a small FIFO that firmware drains.
- Turns raw IR frames into a clean, rate-limited command stream for the light-pattern logic.

---
 rtl/nec_cmd_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_nec_cmd_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_cmd_scheduler.sv
// NEC command scheduler: validates decoded NEC frames, tracks key-held state
// from repeat codes and queues PRESS/REPEAT/RELEASE events in a FWFT FIFO.
module nec_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TMO_W      = 8,
  parameter int unsigned REP_W      = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             tick_i,
  input  logic             frm_valid_i,
  input  logic [7:0]       frm_addr_i,
  input  logic [7:0]       frm_addr_n_i,
  input  logic [7:0]       frm_data_i,
  input  logic [7:0]       frm_data_n_i,
  input  logic             rep_valid_i,
  input  logic             cfg_filt_en_i,
  input  logic [7:0]       cfg_addr_i,
  input  logic [REP_W-1:0] cfg_rep_delay_i,
  input  logic [REP_W-1:0] cfg_rep_rate_i,
  input  logic [TMO_W-1:0] cfg_timeout_i,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic [1:0]       cmd_type_o,
  output logic [7:0]       cmd_addr_o,
  output logic [7:0]       cmd_data_o,
  output logic [4:0]       fifo_cnt_o,
  output logic             ovf_o,
  input  logic             ovf_clr_i,
  output logic [7:0]       err_cnt_o,
  output logic             held_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned ENT_W = 18;

  localparam logic [1:0] T_PRESS   = 2'd0;
  localparam logic [1:0] T_REPEAT  = 2'd1;
  localparam logic [1:0] T_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HELD     = 2'd1,
    S_REL_PEND = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       lat_addr_q, lat_addr_d;
  logic [7:0]       lat_data_q, lat_data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [REP_W-1:0] rcnt_q, rcnt_d, rcnt_inc, rep_thr;
  logic             phase_q, phase_d;

  logic             push_c;
  logic [ENT_W-1:0] push_ent_c;
  logic             push_q;
  logic [ENT_W-1:0] push_ent_q;

  logic frm_ok, frm_bad, frm_acc, tmo_hit;

  // Frame classification and timeout detection
  assign frm_ok   = frm_valid_i && (frm_addr_n_i == ~frm_addr_i) && (frm_data_n_i == ~frm_data_i);
  assign frm_bad  = frm_valid_i && !frm_ok;
  assign frm_acc  = frm_ok && (!cfg_filt_en_i || (frm_addr_i == cfg_addr_i));
  assign tmo_inc  = tmo_q + TMO_W'(1);
  assign rcnt_inc = rcnt_q + REP_W'(1);
  assign rep_thr  = phase_q ? cfg_rep_rate_i : cfg_rep_delay_i;
  assign tmo_hit  = tick_i && ((cfg_timeout_i == TMO_W'(0)) || (tmo_inc == cfg_timeout_i));

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (frm_acc) state_d = S_HELD;
      S_HELD: begin
        if (frm_acc)                   state_d = S_REL_PEND;
        else if (!rep_valid_i && tmo_hit) state_d = S_IDLE;
      end
      S_REL_PEND: state_d = S_HELD;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM outputs: event push request, latch and counter updates
  always_comb begin
    push_c     = 1'b0;
    push_ent_c = {T_PRESS, lat_addr_q, lat_data_q};
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    tmo_d      = tmo_q;
    rcnt_d     = rcnt_q;
    phase_d    = phase_q;
    case (state_q)
      S_IDLE: begin
        if (frm_acc) begin
          push_c     = 1'b1;
          push_ent_c = {T_PRESS, frm_addr_i, frm_data_i};
          lat_addr_d = frm_addr_i;
          lat_data_d = frm_data_i;
          tmo_d      = TMO_W'(0);
          rcnt_d     = REP_W'(0);
          phase_d    = 1'b0;
        end
      end
      S_HELD: begin
        if (frm_acc) begin
          push_c     = 1'b1;
          push_ent_c = {T_RELEASE, lat_addr_q, lat_data_q};
          lat_addr_d = frm_addr_i;
          lat_data_d = frm_data_i;
        end else if (rep_valid_i) begin
          tmo_d = TMO_W'(0);
          if (rep_thr != REP_W'(0)) begin
            if (rcnt_inc == rep_thr) begin
              push_c     = 1'b1;
              push_ent_c = {T_REPEAT, lat_addr_q, lat_data_q};
              rcnt_d     = REP_W'(0);
              phase_d    = 1'b1;
            end else begin
              rcnt_d = rcnt_inc;
            end
          end
        end else if (tick_i) begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            push_c     = 1'b1;
            push_ent_c = {T_RELEASE, lat_addr_q, lat_data_q};
          end
        end
      end
      S_REL_PEND: begin
        push_c     = 1'b1;
        push_ent_c = {T_PRESS, lat_addr_q, lat_data_q};
        tmo_d      = TMO_W'(0);
        rcnt_d     = REP_W'(0);
        phase_d    = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers: latched key, counters, push stage, error count, held flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lat_addr_q <= 8'd0;
      lat_data_q <= 8'd0;
      tmo_q      <= TMO_W'(0);
      rcnt_q     <= REP_W'(0);
      phase_q    <= 1'b0;
      push_q     <= 1'b0;
      push_ent_q <= ENT_W'(0);
      err_cnt_o  <= 8'd0;
      held_o     <= 1'b0;
    end else begin
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      tmo_q      <= tmo_d;
      rcnt_q     <= rcnt_d;
      phase_q    <= phase_d;
      push_q     <= push_c;
      push_ent_q <= push_ent_c;
      if (frm_bad && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'd1;
      held_o     <= (state_d != S_IDLE);
    end
  end

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, remain;
  logic [ENT_W-1:0] head_d;
  logic             do_pop, do_push, ovf_set;

  // FIFO control: a full FIFO only takes a push when it pops in the same cycle
  always_comb begin
    do_pop  = cmd_ready_i && (cnt_q != CNT_W'(0));
    do_push = push_q && ((cnt_q != CNT_W'(FIFO_DEPTH)) || do_pop);
    ovf_set = push_q && !do_push;
    wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PTR_W'(1) : rd_q;
    remain  = cnt_q - CNT_W'(do_pop);
    cnt_d   = remain + CNT_W'(do_push);
    head_d  = ENT_W'(0);
    if (cnt_d != CNT_W'(0)) begin
      if (remain == CNT_W'(0)) head_d = push_ent_q;
      else                     head_d = mem[rd_d];
    end
  end

  // FIFO storage
  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_q] <= push_ent_q;
  end

  // FIFO pointers, count, registered head and overflow flag
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_q        <= PTR_W'(0);
      rd_q        <= PTR_W'(0);
      cnt_q       <= CNT_W'(0);
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= 2'd0;
      cmd_addr_o  <= 8'd0;
      cmd_data_o  <= 8'd0;
      ovf_o       <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      cmd_valid_o <= (cnt_d != CNT_W'(0));
      cmd_type_o  <= head_d[17:16];
      cmd_addr_o  <= head_d[15:8];
      cmd_data_o  <= head_d[7:0];
      if (ovf_set)        ovf_o <= 1'b1;
      else if (ovf_clr_i) ovf_o <= 1'b0;
    end
  end

  assign fifo_cnt_o = cnt_q;

endmodule

// File: tb/tb_nec_cmd_scheduler.sv
// Testbench for nec_cmd_scheduler: scoreboard of expected command events
// checked as the FIFO is drained, plus per-scenario status checks.
module tb_nec_cmd_scheduler;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       tick_i = 1'b0;
  logic       frm_valid_i = 1'b0;
  logic [7:0] frm_addr_i = 8'd0, frm_addr_n_i = 8'd0, frm_data_i = 8'd0, frm_data_n_i = 8'd0;
  logic       rep_valid_i = 1'b0;
  logic       cfg_filt_en_i = 1'b0;
  logic [7:0] cfg_addr_i = 8'd0;
  logic [3:0] cfg_rep_delay_i = 4'd0, cfg_rep_rate_i = 4'd0;
  logic [7:0] cfg_timeout_i = 8'd3;
  logic       cmd_valid_o, cmd_ready_i = 1'b1;
  logic [1:0] cmd_type_o;
  logic [7:0] cmd_addr_o, cmd_data_o;
  logic [4:0] fifo_cnt_o;
  logic       ovf_o, ovf_clr_i = 1'b0;
  logic [7:0] err_cnt_o;
  logic       held_o;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  localparam logic [1:0] PRESS = 2'd0, REPEAT = 2'd1, RELEASE = 2'd2;

  nec_cmd_scheduler #(.FIFO_DEPTH(8), .TMO_W(8), .REP_W(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .tick_i(tick_i),
    .frm_valid_i(frm_valid_i), .frm_addr_i(frm_addr_i), .frm_addr_n_i(frm_addr_n_i),
    .frm_data_i(frm_data_i), .frm_data_n_i(frm_data_n_i), .rep_valid_i(rep_valid_i),
    .cfg_filt_en_i(cfg_filt_en_i), .cfg_addr_i(cfg_addr_i),
    .cfg_rep_delay_i(cfg_rep_delay_i), .cfg_rep_rate_i(cfg_rep_rate_i),
    .cfg_timeout_i(cfg_timeout_i), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_type_o(cmd_type_o), .cmd_addr_o(cmd_addr_o), .cmd_data_o(cmd_data_o),
    .fifo_cnt_o(fifo_cnt_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i),
    .err_cnt_o(err_cnt_o), .held_o(held_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Scoreboard: every entry popped from the DUT must match the oldest expectation
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && cmd_valid_o && cmd_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got type=%0d addr=%h data=%h, expected no entry",
                 cmd_type_o, cmd_addr_o, cmd_data_o);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({cmd_type_o, cmd_addr_o, cmd_data_o} !== e) begin
          bad++;
          $display("FAIL pop_entry: got type=%0d addr=%h data=%h, expected type=%0d addr=%h data=%h",
                   cmd_type_o, cmd_addr_o, cmd_data_o, e[17:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] an,
                            input logic [7:0] d, input logic [7:0] dn);
    frm_addr_i = a; frm_addr_n_i = an; frm_data_i = d; frm_data_n_i = dn;
    frm_valid_i = 1'b1;
    cyc(1);
    frm_valid_i = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0;
  endtask

  task automatic pulse_rep();
    rep_valid_i = 1'b1;
    cyc(1);
    rep_valid_i = 1'b0;
  endtask

  task automatic exp_push(input logic [1:0] t, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({t, a, d});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      cyc(1);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d entries still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    cyc(3);
    wb_rst_i = 1'b0;
    total++;
    if ({cmd_valid_o, fifo_cnt_o, cmd_type_o, cmd_addr_o, cmd_data_o, ovf_o, err_cnt_o, held_o} !== 35'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b cnt=%0d type=%0d addr=%h data=%h ovf=%b err=%0d held=%b, required all 0",
               cmd_valid_o, fifo_cnt_o, cmd_type_o, cmd_addr_o, cmd_data_o, ovf_o, err_cnt_o, held_o);
    end
  endtask

  task automatic test_press_timeout();
    cfg_timeout_i = 8'd3; cmd_ready_i = 1'b1;
    exp_push(PRESS, 8'h5A, 8'h3C);
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3);
    total++;
    if (held_o !== 1'b1) begin bad++; $display("FAIL press_held: held=%b required 1", held_o); end
    cyc(2);
    pulse_tick(); pulse_tick();
    total++;
    if (held_o !== 1'b1) begin bad++; $display("FAIL tick2_held: held=%b required 1", held_o); end
    exp_push(RELEASE, 8'h5A, 8'h3C);
    pulse_tick();
    total++;
    if (held_o !== 1'b0) begin bad++; $display("FAIL release_held: held=%b required 0", held_o); end
    wait_drain("press_timeout");
  endtask

  task automatic test_bad_frames();
    cmd_ready_i = 1'b0;
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'h00);
    cyc(1);
    total++;
    if (err_cnt_o !== 8'd1) begin bad++; $display("FAIL err_one: err=%0d required 1", err_cnt_o); end
    total++;
    if ({fifo_cnt_o, held_o} !== 6'd0) begin
      bad++; $display("FAIL bad_no_push: cnt=%0d held=%b required 0/0", fifo_cnt_o, held_o);
    end
    for (int i = 0; i < 259; i++) send_frame(8'h5A, 8'h00, 8'h3C, 8'hC3);
    cyc(1);
    total++;
    if (err_cnt_o !== 8'd255) begin bad++; $display("FAIL err_sat: err=%0d required 255", err_cnt_o); end
    cmd_ready_i = 1'b1;
  endtask

  task automatic test_filter();
    cmd_ready_i = 1'b0; cfg_filt_en_i = 1'b1; cfg_addr_i = 8'h10;
    send_frame(8'h11, 8'hEE, 8'h22, 8'hDD);
    cyc(2);
    total++;
    if ({fifo_cnt_o, held_o} !== 6'd0) begin
      bad++; $display("FAIL filt_drop: cnt=%0d held=%b required 0/0", fifo_cnt_o, held_o);
    end
    exp_push(PRESS, 8'h10, 8'h22);
    send_frame(8'h10, 8'hEF, 8'h22, 8'hDD);
    cyc(2);
    total++;
    if ({fifo_cnt_o, held_o} !== {5'd1, 1'b1}) begin
      bad++; $display("FAIL filt_pass: cnt=%0d held=%b required 1/1", fifo_cnt_o, held_o);
    end
    cmd_ready_i = 1'b1; cfg_timeout_i = 8'd1;
    exp_push(RELEASE, 8'h10, 8'h22);
    pulse_tick();
    wait_drain("filter");
    cfg_filt_en_i = 1'b0;
  endtask

  task automatic test_repeats();
    cmd_ready_i = 1'b0; cfg_rep_delay_i = 4'd2; cfg_rep_rate_i = 4'd3; cfg_timeout_i = 8'd200;
    exp_push(PRESS, 8'h21, 8'h43);
    send_frame(8'h21, 8'hDE, 8'h43, 8'hBC);
    cyc(1);
    for (int r = 1; r <= 8; r++) begin
      if (r == 2 || r == 5 || r == 8) exp_push(REPEAT, 8'h21, 8'h43);
      pulse_rep();
      cyc(1);
    end
    cyc(2);
    total++;
    if (fifo_cnt_o !== 5'd4) begin bad++; $display("FAIL rep_count: cnt=%0d required 4", fifo_cnt_o); end
    cmd_ready_i = 1'b1;
    wait_drain("repeats");
    cfg_timeout_i = 8'd1;
    exp_push(RELEASE, 8'h21, 8'h43);
    pulse_tick();
    wait_drain("repeats_release");
    cfg_rep_delay_i = 4'd0; cfg_rep_rate_i = 4'd0;
  endtask

  task automatic test_back_to_back();
    cmd_ready_i = 1'b1; cfg_timeout_i = 8'd200;
    exp_push(PRESS, 8'h01, 8'h02);
    send_frame(8'h01, 8'hFE, 8'h02, 8'hFD);
    wait_drain("b2b_first");
    cmd_ready_i = 1'b0;
    exp_push(RELEASE, 8'h01, 8'h02);
    exp_push(PRESS, 8'h01, 8'h07);
    send_frame(8'h01, 8'hFE, 8'h07, 8'hF8);
    cyc(1);
    total++;
    if ({fifo_cnt_o, held_o} !== {5'd1, 1'b1}) begin
      bad++; $display("FAIL b2b_first_cycle: cnt=%0d held=%b required 1/1", fifo_cnt_o, held_o);
    end
    cyc(1);
    total++;
    if ({fifo_cnt_o, held_o} !== {5'd2, 1'b1}) begin
      bad++; $display("FAIL b2b_second_cycle: cnt=%0d held=%b required 2/1", fifo_cnt_o, held_o);
    end
    cmd_ready_i = 1'b1;
    wait_drain("b2b");
    cfg_timeout_i = 8'd1;
    exp_push(RELEASE, 8'h01, 8'h07);
    pulse_tick();
    wait_drain("b2b_release");
  endtask

  task automatic test_fifo_full();
    cmd_ready_i = 1'b0; cfg_timeout_i = 8'd1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a, d;
      a = 8'h40 + 8'(k); d = 8'h80 + 8'(k);
      exp_push(PRESS, a, d);
      send_frame(a, ~a, d, ~d);
      exp_push(RELEASE, a, d);
      pulse_tick();
    end
    cyc(2);
    total++;
    if ({fifo_cnt_o, ovf_o} !== {5'd8, 1'b0}) begin
      bad++; $display("FAIL full_fill: cnt=%0d ovf=%b required 8/0", fifo_cnt_o, ovf_o);
    end
    send_frame(8'h33, 8'hCC, 8'h44, 8'hBB);
    cyc(2);
    total++;
    if ({fifo_cnt_o, ovf_o, held_o} !== {5'd8, 1'b1, 1'b1}) begin
      bad++; $display("FAIL full_drop: cnt=%0d ovf=%b held=%b required 8/1/1", fifo_cnt_o, ovf_o, held_o);
    end
    exp_push(RELEASE, 8'h33, 8'h44);
    tick_i = 1'b1;
    cyc(1);
    tick_i = 1'b0; cmd_ready_i = 1'b1;
    cyc(1);
    cmd_ready_i = 1'b0;
    total++;
    if ({fifo_cnt_o, ovf_o} !== {5'd8, 1'b1}) begin
      bad++; $display("FAIL full_push_pop: cnt=%0d ovf=%b required 8/1", fifo_cnt_o, ovf_o);
    end
    ovf_clr_i = 1'b1;
    cyc(1);
    ovf_clr_i = 1'b0;
    total++;
    if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_clear: ovf=%b required 0", ovf_o); end
    cmd_ready_i = 1'b1;
    wait_drain("fifo_full");
  endtask

  task automatic test_mid_reset();
    cmd_ready_i = 1'b0; cfg_timeout_i = 8'd1;
    send_frame(8'h66, 8'h99, 8'h77, 8'h88);
    cyc(2);
    total++;
    if ({fifo_cnt_o, held_o} !== {5'd1, 1'b1}) begin
      bad++; $display("FAIL pre_reset: cnt=%0d held=%b required 1/1", fifo_cnt_o, held_o);
    end
    wb_rst_i = 1'b1;
    cyc(1);
    wb_rst_i = 1'b0;
    total++;
    if ({cmd_valid_o, fifo_cnt_o, cmd_type_o, cmd_addr_o, cmd_data_o, ovf_o, err_cnt_o, held_o} !== 35'd0) begin
      bad++;
      $display("FAIL mid_reset: valid=%b cnt=%0d type=%0d addr=%h data=%h ovf=%b err=%0d held=%b, required all 0",
               cmd_valid_o, fifo_cnt_o, cmd_type_o, cmd_addr_o, cmd_data_o, ovf_o, err_cnt_o, held_o);
    end
    cmd_ready_i = 1'b1;
    pulse_tick();
    cyc(3);
    total++;
    if (fifo_cnt_o !== 5'd0) begin bad++; $display("FAIL no_release_after_reset: cnt=%0d required 0", fifo_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_press_timeout();
    test_bad_frames();
    test_filter();
    test_repeats();
    test_back_to_back();
    test_fifo_full();
    test_mid_reset();
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
